// File: rtl/uart_cfg_core.sv
// uart_cfg_core: parameterised UART with TX FIFO, RX holding register,
// parity/framing checks, overrun detection and internal loopback.
`timescale 1ns/1ps
module uart_cfg_core #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx_data,
  output logic                 tx_data,
  input  logic [DATA_BITS-1:0] tx_wdata,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_rdata,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 loopback
);

  localparam int unsigned DIV    = CLK_FREQ / BAUD;
  localparam int unsigned HALF   = DIV / 2;
  localparam int unsigned CNT_W  = $clog2(DIV);
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned PTR_W  = $clog2(TX_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam logic        PAR_EN  = (PARITY != 0);
  localparam logic        ODD_PAR = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] fifo_q [TX_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]    count_q, count_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 push_c;
  logic                 pop_c;
  logic [DATA_BITS-1:0] fifo_rd_c;

  assign push_c    = tx_valid && tx_ready_q;
  assign fifo_rd_c = fifo_q[rd_ptr_q];

  // FIFO pointer/count next state; a full FIFO refuses pushes regardless of pops
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + FCNT_W'(push_c) - FCNT_W'(pop_c);
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    tx_ready_d = (count_d < FCNT_W'(TX_DEPTH));
  end

  // FIFO control registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // FIFO storage, no reset needed since count gates every read
  always_ff @(posedge sys_clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= tx_wdata;
  end

  // ---------------------------------------------------------------------------
  // TX serializer
  // ---------------------------------------------------------------------------
  state_e               tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_bit_c;
  logic                 tx_bit_end_c;
  logic                 ser_q;
  logic                 tx_data_q;

  assign tx_bit_end_c = (tx_cnt_q == CNT_W'(DIV - 1));

  // TX FSM next state and the serial bit for the current state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    pop_c      = 1'b0;
    tx_bit_c   = 1'b1;
    unique case (tx_state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop_c      = 1'b1;
          tx_state_d = ST_START;
          tx_cnt_d   = '0;
        end
      end
      ST_START: begin
        tx_bit_c = 1'b0;
        if (tx_bit_end_c) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        tx_bit_c = tx_shift_q[0];
        if (tx_bit_end_c) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_idx_q == IDX_W'(DATA_BITS - 1)) begin
            tx_idx_d   = '0;
            tx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            tx_idx_d = tx_idx_q + IDX_W'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        tx_bit_c = tx_par_q;
        if (tx_bit_end_c) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = ST_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        tx_bit_c = 1'b1;
        if (tx_bit_end_c) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IDX_W'(STOP_BITS - 1)) begin
            tx_idx_d = '0;
            // Chain straight into the next start bit when more data waits
            if (count_q != '0) begin
              pop_c      = 1'b1;
              tx_state_d = ST_START;
            end else begin
              tx_state_d = ST_IDLE;
            end
          end else begin
            tx_idx_d = tx_idx_q + IDX_W'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    if (pop_c) begin
      tx_shift_d = fifo_rd_c;
      tx_par_d   = (^fifo_rd_c) ^ ODD_PAR;
    end
  end

  // TX FSM state and serial line registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      ser_q      <= 1'b1;
      tx_data_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      ser_q      <= tx_bit_c;
      tx_data_q  <= loopback ? 1'b1 : tx_bit_c;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_ready = tx_ready_q;

  // ---------------------------------------------------------------------------
  // RX deserializer
  // ---------------------------------------------------------------------------
  logic [1:0]           sync_q;
  logic                 rx_in_c;
  state_e               rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_pbad_q, rx_pbad_d;
  logic                 rx_done_c;
  logic                 rx_fbad_c;
  logic                 rx_bit_end_c;

  assign rx_in_c      = sync_q[1];
  assign rx_bit_end_c = (rx_cnt_q == CNT_W'(DIV - 1));

  // Two-flop synchronizer on the selected receive source
  always_ff @(posedge sys_clk) begin
    if (sys_rst) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], loopback ? ser_q : rx_data};
  end

  // RX FSM next state: half-bit start check, then mid-bit sampling
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_pbad_d  = rx_pbad_q;
    rx_done_c  = 1'b0;
    rx_fbad_c  = 1'b0;
    unique case (rx_state_q)
      ST_IDLE: begin
        if (!rx_in_c) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
          rx_pbad_d  = 1'b0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == CNT_W'(HALF - 1)) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_in_c ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_bit_end_c) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_in_c, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == IDX_W'(DATA_BITS - 1)) begin
            rx_idx_d   = '0;
            rx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            rx_idx_d = rx_idx_q + IDX_W'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (rx_bit_end_c) begin
          rx_cnt_d   = '0;
          rx_pbad_d  = rx_in_c != ((^rx_shift_q) ^ ODD_PAR);
          rx_state_d = ST_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (rx_bit_end_c) begin
          rx_cnt_d   = '0;
          rx_done_c  = 1'b1;
          rx_fbad_c  = !rx_in_c;
          rx_state_d = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // RX FSM state registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_pbad_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_pbad_q  <= rx_pbad_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX holding register and handshake
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] rx_rdata_q, rx_rdata_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;

  // Load on frame completion if the slot is free or being drained, else drop
  always_comb begin
    rx_rdata_d = rx_rdata_q;
    rx_valid_d = rx_valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (rx_done_c) begin
      if (!rx_valid_q || rx_ready) begin
        rx_rdata_d = rx_shift_q;
        rx_valid_d = 1'b1;
        perr_d     = rx_pbad_q;
        ferr_d     = rx_fbad_c;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Holding register outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_rdata_q <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_rdata_q <= rx_rdata_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_rdata   = rx_rdata_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_cfg_core.md
UART_CFG_CORE -- requirements
Module: uart_cfg_core

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 The block SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, stop bits transmitted, legal values 1 or 2.
REQ-006 The block SHALL have parameter TX_DEPTH, default 4, TX FIFO entries, power of two and at least 2.
REQ-007 The block SHALL have these ports:
- sys_clk  in  1  single clock; one clock domain.
- sys_rst  in  1  reset, synchronous, active-high.
- rx_data  in  1  serial receive line, asynchronous, idle high.
- tx_data  out  1  serial transmit line, idle high.
- tx_wdata  in  DATA_BITS  word to transmit.
- tx_valid  in  1  write request.
- tx_ready  out  1  FIFO can accept a word.
- rx_rdata  out  DATA_BITS  received word.
- rx_valid  out  1  received word available.
- rx_ready  in  1  consumer accepts the word.
- parity_err  out  1  parity error on the word at rx_rdata.
- frame_err  out  1  stop-bit error on the word at rx_rdata.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- loopback  in  1  1 = internal TX-to-RX loop.

Function
REQ-008 The bit period SHALL be DIV = CLK_FREQ/BAUD (truncated), and HALF SHALL be DIV/2; the defaults give 434 cycles.
REQ-009 A TX word SHALL be accepted on every edge where tx_valid and tx_ready are both 1; tx_ready SHALL equal (count < TX_DEPTH).
REQ-010 When the FIFO is full, a push SHALL be refused even if a pop happens in the same cycle; a push and pop in the same cycle when not full SHALL leave count unchanged.
REQ-011 The TX FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-012 In IDLE with the FIFO non-empty, the TX FSM SHALL pop one word; tx_data SHALL go low exactly 2 cycles after the accepting edge when the FIFO was previously empty and the FSM idle.
REQ-013 Each TX bit SHALL last DIV cycles, in this order:
- start bit 0;
- DATA_BITS data bits, LSB first;
- parity bit, only if PARITY != 0;
- STOP_BITS stop bits of 1.
REQ-014 The parity bit SHALL be the XOR of the data bits for even parity, and its inverse for odd parity.
REQ-015 After the last stop bit, if the FIFO is non-empty, the next start bit SHALL begin on the following cycle with no idle gap.
REQ-016 The RX input SHALL pass through a 2-flop synchronizer; the source SHALL be rx_data when loopback=0 and the internal serializer output when loopback=1.
REQ-017 When loopback=1, tx_data SHALL be held at 1.
REQ-018 If loopback changes mid-frame, the frame in progress MAY be corrupted; no other effect SHALL result.
REQ-019 The RX FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-020 The RX FSM SHALL leave IDLE when the synchronized input is 0.
REQ-021 In START, the RX FSM SHALL sample after HALF cycles; if the sample is 1, it SHALL return to IDLE with no flags (glitch reject).
REQ-022 After START, the RX FSM SHALL sample every DIV cycles at mid-bit: data LSB first, then parity if enabled, then the first stop bit only.
REQ-023 If the stop sample is 0, frame_err SHALL be 1 for that word; if the parity sample mismatches, parity_err SHALL be 1.
REQ-024 The RX FSM SHALL return to IDLE on the cycle after the stop sample.
REQ-025 The word SHALL be loaded into rx_rdata with rx_valid=1 on the cycle after the stop sample, even when parity_err or frame_err is set.
REQ-026 parity_err and frame_err SHALL be updated together with each load and held with rx_rdata.
REQ-027 rx_valid SHALL stay 1 until an edge where rx_valid and rx_ready are both 1; rx_valid SHALL clear there unless a new word loads in the same cycle.
REQ-028 If a frame completes while rx_valid=1 and rx_ready=0:
- overrun SHALL pulse for 1 cycle;
- the new word SHALL be discarded;
- rx_rdata and the error flags SHALL keep the old word.
REQ-029 If a frame completes in the same cycle rx_ready accepts the old word, the new word SHALL load and overrun SHALL stay 0.

Reset
REQ-030 While sys_rst=1 at a clock edge, the block SHALL set tx_data=1, tx_ready=1, rx_valid=0, rx_rdata=0, parity_err=0, frame_err=0 and overrun=0.
REQ-031 Reset SHALL empty the FIFO and set both FSMs and all counters to IDLE/0.
REQ-032 Reset mid-frame SHALL abort the frame; tx_data SHALL be 1 from the first reset edge, and no partial word SHALL be delivered.
REQ-033 After reset is released, the first tx_valid SHALL be accepted on the next edge.

Verification
REQ-034 The bench SHALL cover these scenarios with default parameters unless stated:
- RX basic: frame 0x55 on rx_data at 8680 ns per bit, stop=1 -> rx_rdata=0x55, rx_valid=1, parity_err=0, frame_err=0.
- Frame error: 0xA5 with stop bit driven 0 -> rx_rdata=0xA5, frame_err=1.
- Parity error: PARITY=2, 0x03 sent with parity bit 1 -> parity_err=1.
- Glitch: rx_data low for 100 cycles only -> no rx_valid.
- TX burst: 6 words 0x01..0x06 pushed back-to-back -> tx_ready drops once 4 entries are queued; all 6 words sent in order; each frame is 4340 cycles with no gaps.
- Loopback, overrun and reset: loopback=1, push 0xA3 -> rx_rdata=0xA3 and tx_data constantly 1. Then two frames with rx_ready=0 -> overrun pulses once and rx_rdata stays at the first word. Then sys_rst mid-frame -> all outputs return to their reset values.
